multicycle_cpu: RTL and testbench
=================================

// Module: multicycle_cpu
// PURPOSE
//   Multicycle MIPS-subset core: the next generation of the single-cycle CPU top.
//   One unified instruction/data memory port with a req/ready handshake, so
//   memory latency is variable. A control FSM sequences fetch, decode, execute,
//   memory and writeback. Sits between the test harness memory model and the
//   existing register file.
// PARAMETERS
//   RESET_PC    32'h0000_0000  PC value loaded on reset
//   ADDR_W      32             implemented PC/address bits; PC wraps modulo 2^ADDR_W
//   HALT_ON_ILL 1              1: illegal opcode -> HALT; 0: illegal opcode executes as NOP
// PORTS
//   clk        in   1       system clock, rising edge
//   reset_n    in   1       asynchronous, active-low reset
//   mem_req    out  1       memory request valid
//   mem_we     out  1       1 = store, 0 = load/fetch
//   mem_addr   out  ADDR_W  byte address, word-aligned (bits[1:0] = 0)
//   mem_wdata  out  32      store data
//   mem_rdata  in   32      read data; valid in the cycle mem_ready = 1
//   mem_ready  in   1       transfer completes on the clk edge where req & ready
//   pc_out     out  ADDR_W  PC of the instruction in flight (debug)
//   retire     out  1       1-cycle pulse as each instruction completes
//   halt       out  1       core stopped; stays high until reset
// BEHAVIOUR
//   Reset (async, any state, mid-transaction included):
//     - state = FETCH, PC = RESET_PC.
//     - mem_req, mem_we, retire, halt = 0; mem_addr, mem_wdata = 0.
//     - Any pending transfer is abandoned.
//     - GPR contents undefined, except $0 = 0.
//   Handshake:
//     - Once mem_req is raised, mem_addr, mem_we and mem_wdata are held stable
//       until the edge where mem_ready = 1.
//     - The FSM stays in its state while mem_ready = 0.
//     - mem_ready while mem_req = 0 is ignored.
//   FSM states:
//     FETCH : req at PC. On ready: IR <= rdata, PC <= PC+4, go to DECODE.
//     DECODE: read rs/rt; branch target = PC + (sext(imm) << 2).
//             Illegal opcode/funct -> HALT (HALT_ON_ILL = 1), otherwise retire as NOP.
//     EXEC  : ALU operation.
//               beq/bne: taken -> PC <= target. Retire, go to FETCH.
//               j      : PC <= {PC[31:28], addr, 2'b00}. Retire, go to FETCH.
//               jal    : same as j, and $31 <= PC. Retire, go to FETCH.
//               jr     : PC <= rs. Retire, go to FETCH.
//               lw/sw  : go to MEM.
//               others : go to WB.
//     MEM   : lw/sw address = rs + sext(imm). sw: wdata = rt, we = 1.
//             On ready: sw retires and goes to FETCH; lw latches MDR and goes to WB.
//     WB    : write rd (R-type) or rt (addi, xori, lw). Retire, go to FETCH.
//     HALT  : halt = 1, mem_req = 0. Exit only by reset.
//   ISA: add, sub, slt, and, or (R-type); addi, xori, lw, sw, beq, bne, j, jal, jr.
//   Arithmetic:
//     - add/sub/addi wrap modulo 2^32; no overflow trap.
//     - slt is signed.
//     - addi sign-extends imm; xori zero-extends imm.
//   Writes to $0 are discarded. Reads of $0 return 0.
//   Latency (zero-wait memory, ready same cycle as req):
//     branch/jump = 3 cycles; R-type/imm = 4; sw = 4; lw = 5.
//     Each wait cycle adds 1.
//   retire asserts in the final cycle of each instruction.
//   Misaligned lw/sw address (bits[1:0] != 0) -> HALT, no memory request issued.
//   PC wrap: PC+4 at 2^ADDR_W-4 gives 0.
// STRUCTURE
//   cpu_defs.vh (shared include):
//     - opcode and funct localparams
//     - ALU_op encoding
//     - FSM state encoding
//   Sub-module: regfile (existing register/regfile.v); 2 read ports, 1 write port, $0 forced to 0.
//   Everything else (FSM, ALU, IR/MDR/PC registers, muxes) is internal to multicycle_cpu.
// TESTING
//   1. reset_n low, then high; memory holds addi $1,$0,5 at 0.
//      -> first req at 0x0; $1 = 5 after 4 cycles; retire pulses once.
//   2. add $3,$1,$2 with $1 = 32'hFFFF_FFFF, $2 = 2 -> $3 = 1.
//      slt $4,$1,$2 -> $4 = 1 (signed compare).
//   3. sw $1,8($0) then lw $5,8($0), with mem_ready delayed 3 cycles.
//      -> addr/wdata stable while waiting; $5 = $1; sw takes 7 cycles, lw takes 8.
//   4. beq $0,$0,-1 at 0x10 -> PC returns to 0x10; 3 cycles per iteration.
//      jal at 0x20 -> $31 = 0x24.
//   5. Illegal opcode 6'h3F -> halt = 1 and mem_req = 0 on every later cycle.
//      lw at address 0x2 -> halt = 1 and no request issued.
//   6. reset_n pulsed low while waiting in MEM -> mem_req drops immediately;
//      after release, the first fetch is from RESET_PC.

Source files
------------

// File: rtl/multicycle_cpu_pkg.sv
// Shared encodings for the multicycle MIPS-subset core: opcodes, functs, FSM states,
// ALU operations, instruction classes and the decode/ALU helper functions.
package multicycle_cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT} alu_op_e;
  typedef enum logic [3:0] {
    K_ALU_R, K_ALU_I, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_ILL
  } kind_e;

  typedef struct packed {
    kind_e   kind;
    alu_op_e alu_op;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] ir);
    dec_t d;
    d.kind   = K_ILL;
    d.alu_op = ALU_ADD;
    case (ir[31:26])
      OP_RTYPE: begin
        case (ir[5:0])
          FN_ADD:  d.kind = K_ALU_R;
          FN_SUB:  begin d.kind = K_ALU_R; d.alu_op = ALU_SUB; end
          FN_AND:  begin d.kind = K_ALU_R; d.alu_op = ALU_AND; end
          FN_OR:   begin d.kind = K_ALU_R; d.alu_op = ALU_OR;  end
          FN_SLT:  begin d.kind = K_ALU_R; d.alu_op = ALU_SLT; end
          FN_JR:   d.kind = K_JR;
          default: d.kind = K_ILL;
        endcase
      end
      OP_ADDI: d.kind = K_ALU_I;
      OP_XORI: begin d.kind = K_ALU_I; d.alu_op = ALU_XOR; end
      OP_LW:   d.kind = K_LW;
      OP_SW:   d.kind = K_SW;
      OP_BEQ:  d.kind = K_BEQ;
      OP_BNE:  d.kind = K_BNE;
      OP_J:    d.kind = K_J;
      OP_JAL:  d.kind = K_JAL;
      default: d.kind = K_ILL;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a,
                                      input logic [31:0] b);
    case (op)
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLT: return {31'd0, ($signed(a) < $signed(b))};
      default: return a + b;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_cpu_regfile.sv
// 32 x 32-bit register file: two asynchronous read ports, one synchronous write port.
// Register $0 reads as zero and ignores writes.
module multicycle_cpu_regfile (
  input  logic        clk,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);

  logic [31:0] regs_q [0:31];

  always_ff @(posedge clk) begin
    if (we_i && (wa_i != 5'd0)) regs_q[wa_i] <= wd_i;
  end

  assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : regs_q[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : regs_q[ra2_i];

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB sequencing over a single
// req/ready memory port. Memory-side outputs are registered and held until ready.
module multicycle_cpu
  import multicycle_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ADDR_W      = 32,
  parameter bit          HALT_ON_ILL = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic              retire,
  output logic              halt
);

  state_e            state_q;
  kind_e             kind_q;
  alu_op_e           alu_op_q;
  logic [ADDR_W-1:0] pc_q, ipc_q, addr_q, bt_q;
  logic              req_q, we_q, halt_q;
  logic [31:0]       wdata_q, ir_q, a_q, b_q, opb_q, alu_q, mdr_q;

  dec_t              dec_d;
  logic [31:0]       rs_val, rt_val, sext_imm, zext_imm, alu_d, pc_ext, rf_wd;
  logic [ADDR_W-1:0] pc_inc_d, pc_exec_d;
  logic              rf_we;
  logic [4:0]        rf_wa;

  assign dec_d    = decode(ir_q);
  assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};
  assign zext_imm = {16'd0, ir_q[15:0]};
  assign alu_d    = alu(alu_op_q, a_q, opb_q);
  assign pc_ext   = 32'(pc_q);
  assign pc_inc_d = pc_q + ADDR_W'(32'd4);

  always_comb begin
    pc_exec_d = pc_q;
    case (kind_q)
      K_BEQ:     if (a_q == b_q) pc_exec_d = bt_q;
      K_BNE:     if (a_q != b_q) pc_exec_d = bt_q;
      K_J, K_JAL: pc_exec_d = ADDR_W'({pc_ext[31:28], ir_q[25:0], 2'b00});
      K_JR:      pc_exec_d = ADDR_W'(a_q);
      default:   pc_exec_d = pc_q;
    endcase
  end

  // jal links in EXEC; every other register write happens in WB
  always_comb begin
    rf_we = (state_q == S_WB) || ((state_q == S_EXEC) && (kind_q == K_JAL));
    rf_wa = (kind_q == K_JAL) ? 5'd31 : (kind_q == K_ALU_R) ? ir_q[15:11] : ir_q[20:16];
    rf_wd = (kind_q == K_JAL) ? pc_ext : (kind_q == K_LW) ? mdr_q : alu_q;
  end

  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_DECODE: retire = (dec_d.kind == K_ILL) && !HALT_ON_ILL;
      S_EXEC:   retire = kind_q inside {K_BEQ, K_BNE, K_J, K_JAL, K_JR};
      S_MEM:    retire = mem_ready && (kind_q == K_SW);
      S_WB:     retire = 1'b1;
      default:  retire = 1'b0;
    endcase
  end

  multicycle_cpu_regfile u_regfile (
    .clk   (clk),
    .ra1_i (ir_q[25:21]),
    .ra2_i (ir_q[20:16]),
    .rd1_o (rs_val),
    .rd2_o (rt_val),
    .we_i  (rf_we),
    .wa_i  (rf_wa),
    .wd_i  (rf_wd)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_FETCH;
      pc_q     <= ADDR_W'(RESET_PC);
      ipc_q    <= ADDR_W'(RESET_PC);
      kind_q   <= K_ILL;
      alu_op_q <= ALU_ADD;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      halt_q   <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (!req_q) begin
            req_q  <= 1'b1;
            addr_q <= pc_q;
            we_q   <= 1'b0;
          end else if (mem_ready) begin
            req_q   <= 1'b0;
            ipc_q   <= pc_q;
            pc_q    <= pc_inc_d;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          kind_q   <= dec_d.kind;
          alu_op_q <= dec_d.alu_op;
          if (dec_d.kind != K_ILL) begin
            state_q <= S_EXEC;
          end else if (HALT_ON_ILL) begin
            state_q <= S_HALT;
            halt_q  <= 1'b1;
          end else begin
            state_q <= S_FETCH;
            req_q   <= 1'b1;
            addr_q  <= pc_q;
          end
        end
        S_EXEC: begin
          case (kind_q)
            K_LW, K_SW: begin
              // a misaligned effective address stops the core before any request
              if (alu_d[1:0] != 2'b00) begin
                state_q <= S_HALT;
                halt_q  <= 1'b1;
              end else begin
                state_q <= S_MEM;
                req_q   <= 1'b1;
                we_q    <= (kind_q == K_SW);
                addr_q  <= ADDR_W'(alu_d);
                wdata_q <= (kind_q == K_SW) ? b_q : 32'd0;
              end
            end
            K_ALU_R, K_ALU_I: state_q <= S_WB;
            default: begin
              pc_q    <= pc_exec_d;
              state_q <= S_FETCH;
              req_q   <= 1'b1;
              addr_q  <= pc_exec_d;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
            if (kind_q == K_SW) begin
              state_q <= S_FETCH;
              addr_q  <= pc_q;
            end else begin
              req_q   <= 1'b0;
              state_q <= S_WB;
            end
          end
        end
        S_WB: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
          addr_q  <= pc_q;
        end
        default: begin
          state_q <= S_HALT;
          req_q   <= 1'b0;
          halt_q  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    case (state_q)
      S_FETCH:  if (req_q && mem_ready) ir_q <= mem_rdata;
      S_DECODE: begin
        a_q   <= rs_val;
        b_q   <= rt_val;
        bt_q  <= pc_q + ADDR_W'({sext_imm[29:0], 2'b00});
        opb_q <= (dec_d.kind == K_ALU_R) ? rt_val :
                 (ir_q[31:26] == OP_XORI) ? zext_imm : sext_imm;
      end
      S_EXEC:   alu_q <= alu_d;
      S_MEM:    if (mem_ready) mdr_q <= mem_rdata;
      default:  ;
    endcase
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign pc_out    = (state_q == S_FETCH) ? pc_q : ipc_q;
  assign halt      = halt_q;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Scoreboard bench for multicycle_cpu: an ISA-level interpreter predicts every retirement
// (PC, latency, store traffic); a monitor checks each retire pulse against that queue.
module tb_multicycle_cpu;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_req, mem_we, retire, halt;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata, pc_out;
  logic [31:0] mem_rdata = 32'd0;

  multicycle_cpu dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc_out    (pc_out),
    .retire    (retire),
    .halt      (halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          lat;
    bit          st;
    logic [31:0] sa;
    logic [31:0] sd;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] tbmem [0:1023];
  int          n_cmp = 0, n_bad = 0;
  int          minw = 0, maxw = 0, n_req = 0, wl = 0, p = 0;
  bit          busy = 1'b0;
  logic [31:0] h_addr, h_wdata;
  logic        h_we;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(int fn, int rs, int rt, int rd);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
  endfunction
  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] enc_j(int op, int tgt);
    return {6'(op), 26'(tgt)};
  endfunction

  task automatic emit(input logic [31:0] w);
    tbmem[p] = w;
    p++;
  endtask

  // Instruction-set interpreter over a private copy of memory.
  task automatic run_model();
    logic [31:0] m [0:1023];
    logic [31:0] r [0:31];
    logic [31:0] pc, npc, ins, a, b, simm, wv, ad;
    int wd;
    bit wr, legal;
    exp_t e;
    m = tbmem;
    for (int i = 0; i < 32; i++) r[i] = 32'd0;
    pc = 32'd0;
    for (int step = 0; step < 4000; step++) begin
      ins  = m[pc[11:2]];
      a    = r[ins[25:21]];
      b    = r[ins[20:16]];
      simm = {{16{ins[15]}}, ins[15:0]};
      npc  = pc + 32'd4;
      e.pc = pc; e.st = 1'b0; e.sa = 32'd0; e.sd = 32'd0; e.lat = 4;
      wr = 1'b0; legal = 1'b1; wd = 0; wv = 32'd0; ad = a + simm;
      case (int'(ins[31:26]))
        'h00: begin
          wr = 1'b1; wd = int'(ins[15:11]);
          case (int'(ins[5:0]))
            'h20: wv = a + b;
            'h22: wv = a - b;
            'h24: wv = a & b;
            'h25: wv = a | b;
            'h2A: wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            'h08: begin wr = 1'b0; npc = a; e.lat = 3; end
            default: legal = 1'b0;
          endcase
        end
        'h08: begin wr = 1'b1; wd = int'(ins[20:16]); wv = a + simm; end
        'h0E: begin wr = 1'b1; wd = int'(ins[20:16]); wv = a ^ {16'd0, ins[15:0]}; end
        'h23: begin
          if (ad[1:0] != 2'b00) legal = 1'b0;
          else begin wr = 1'b1; wd = int'(ins[20:16]); wv = m[ad[11:2]]; e.lat = 5; end
        end
        'h2B: begin
          if (ad[1:0] != 2'b00) legal = 1'b0;
          else begin e.st = 1'b1; e.sa = ad; e.sd = b; m[ad[11:2]] = b; end
        end
        'h04: begin e.lat = 3; if (a == b) npc = npc + (simm << 2); end
        'h05: begin e.lat = 3; if (a != b) npc = npc + (simm << 2); end
        'h02: begin e.lat = 3; npc = {npc[31:28], ins[25:0], 2'b00}; end
        'h03: begin
          e.lat = 3; wr = 1'b1; wd = 31; wv = pc + 32'd4;
          npc = {npc[31:28], ins[25:0], 2'b00};
        end
        default: legal = 1'b0;
      endcase
      if (!legal) return;
      if (wr && wd != 0) r[wd] = wv;
      exp_q.push_back(e);
      pc = npc;
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 1024; i++) tbmem[i] = $urandom;
    p = 0;
  endtask

  task automatic build_random();
    int fns[5] = '{'h20, 'h22, 'h24, 'h25, 'h2A};
    int jal_at, k;
    fill_mem();
    for (int r = 1; r <= 7; r++) emit(enc_i('h08, 0, r, int'($urandom_range(0, 65535))));
    emit(enc_i('h08, 0, 1, -1));
    emit(enc_i('h08, 0, 2, 2));
    emit(enc_r('h20, 1, 2, 3));
    emit(enc_r('h2A, 1, 2, 4));
    repeat (30) begin
      k = int'($urandom_range(0, 8));
      if (k < 5)
        emit(enc_r(fns[k], int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7))));
      else if (k == 5)
        emit(enc_i('h08, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 65535))));
      else if (k == 6)
        emit(enc_i('h0E, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 65535))));
      else
        emit(enc_i((k == 7) ? 'h23 : 'h2B, 0, int'($urandom_range(0, 7)),
                   'h400 + 4 * int'($urandom_range(0, 15))));
    end
    emit(enc_i('h08, 0, 8, 3));
    emit(enc_i('h08, 8, 8, -1));
    emit(enc_i('h05, 8, 0, -2));
    emit(enc_i('h04, 0, 0, 1));
    emit(enc_i('h08, 0, 7, 'h77));
    emit(enc_i('h05, 0, 0, 5));
    jal_at = p;
    emit(32'd0);
    emit(enc_j('h02, p + 2));
    emit(enc_i('h08, 0, 1, 'h55));
    for (int r = 1; r <= 8; r++) emit(enc_i('h2B, 0, r, 'h480 + 4 * r));
    emit(enc_i('h2B, 0, 31, 'h480 + 4 * 31));
    emit(32'hFC00_0000);
    tbmem[jal_at] = enc_j('h03, p);
    emit(enc_i('h08, 6, 6, 1));
    emit(enc_r('h08, 31, 0, 0));
  endtask

  task automatic start_run();
    reset_n = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_retire", retire, 0);
    chk("rst_halt", halt, 0);
    chk("rst_pc", pc_out, 0);
    run_model();
    n_req = 0;
    reset_n = 1'b1;
  endtask

  task automatic finish_run();
    int c = 0;
    while (!halt && c < 20000) begin
      @(negedge clk);
      c++;
    end
    chk("halt_reached", halt, 1);
    chk("exp_left", exp_q.size(), 0);
    repeat (8) begin
      @(negedge clk);
      chk("halt_hold", halt, 1);
      chk("halt_noreq", mem_req, 0);
    end
  endtask

  // Memory responder: random wait states, inputs change just after the rising edge.
  always @(posedge clk) begin
    if (reset_n && mem_req && mem_ready) begin
      if (mem_we) tbmem[mem_addr[11:2]] = mem_wdata;
      busy = 1'b0;
    end
    #1;
    if (!reset_n) begin
      busy = 1'b0;
      mem_ready = 1'b0;
    end else if (mem_req) begin
      if (!busy) begin
        busy = 1'b1;
        n_req++;
        wl = int'($urandom_range(maxw, minw));
        h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
      end else begin
        chk("hold_addr", mem_addr, h_addr);
        chk("hold_we", mem_we, h_we);
        chk("hold_wdata", mem_wdata, h_wdata);
        if (wl > 0) wl--;
      end
      mem_ready = (wl == 0);
      mem_rdata = mem_ready ? tbmem[mem_addr[11:2]] : $urandom;
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
    end
  end

  int cnt = 0, waits = 0;
  bit started = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      cnt = 0; waits = 0; started = 1'b0;
    end else begin
      if (mem_req) started = 1'b1;
      if (started) begin
        cnt++;
        if (mem_req && !mem_ready) waits++;
      end
      if (retire) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_retire: got retire at pc %0h expected none", pc_out);
        end else begin
          e = exp_q.pop_front();
          chk("retire_pc", pc_out, e.pc);
          chk("latency", cnt, e.lat + waits);
          if (e.st) begin
            chk("st_we", mem_we, 1);
            chk("st_addr", mem_addr, e.sa);
            chk("st_data", mem_wdata, e.sd);
          end
        end
        cnt = 0; waits = 0;
      end
    end
  end

  initial begin
    int c;
    for (int run = 0; run < 4; run++) begin
      build_random();
      minw = 0;
      maxw = (run == 0) ? 0 : 3;
      start_run();
      finish_run();
    end

    fill_mem();
    emit(enc_i('h23, 0, 5, 2));
    emit(32'hFC00_0000);
    minw = 0; maxw = 2;
    start_run();
    finish_run();
    chk("misaligned_reqs", n_req, 1);

    fill_mem();
    emit(enc_i('h2B, 0, 0, 'h400));
    emit(32'hFC00_0000);
    minw = 20; maxw = 20;
    start_run();
    c = 0;
    while (!(mem_req && mem_we) && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("store_req_seen", mem_req & mem_we, 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_we", mem_we, 0);
    exp_q.delete();
    minw = 0; maxw = 0;
    @(negedge clk);
    run_model();
    reset_n = 1'b1;
    c = 0;
    while (!mem_req && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("refetch_addr", mem_addr, 0);
    chk("refetch_we", mem_we, 0);
    finish_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
